// File: rtl/cfg_bitstream_loader.sv
// -----------------------------------------------------------------------------
// cfg_bitstream_loader
//
// Feeds the configuration scan chain. Configuration words arrive over a
// valid/ready stream and are serialised MSB first onto cfg_head, with cfg_en
// high for exactly one chain shift per cycle. Exactly CHAIN_LEN bits are
// shifted per load; when CHAIN_LEN is not a multiple of WORD_W, the last word
// contributes only its low (CHAIN_LEN mod WORD_W) bits. A one-cycle done pulse
// marks completion.
//
// Optional feature (macro CFG_LOADER_CRC_EN): a CRC-16-CCITT (poly 0x1021,
// init 0xFFFF, no reflection, no final XOR) runs over every shifted bit. After
// the last shift, one trailer word is accepted and its low 16 bits are compared
// against the CRC. crc_err holds a mismatch until the next accepted start or
// reset. Without the macro there is no trailer and crc_err is tied low.
//
// Ports:
//   cfg_clk   in   configuration clock (only clock)
//   cfg_rst   in   synchronous active-high reset
//   start     in   begin a load; sampled only when idle
//   in_data   in   configuration word (WORD_W bits)
//   in_valid  in   in_data valid
//   in_ready  out  word accepted this cycle when in_valid is also high
//   cfg_head  out  serial bit to the chain head (0 when cfg_en is low)
//   cfg_en    out  chain shift enable
//   busy      out  load in progress
//   done      out  single-cycle completion pulse
//   crc_err   out  trailer CRC mismatch flag
// -----------------------------------------------------------------------------
module cfg_bitstream_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 32
) (
    input  logic              cfg_clk,
    input  logic              cfg_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_head,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);
    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
`ifdef CFG_LOADER_CRC_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [RW-1:0]     rem;        // bits still to shift in this load
    logic [BW-1:0]     bit_cnt;    // bits still to shift from the current word
    logic [WORD_W-1:0] shreg;
    logic [31:0]       rem_ext;
    logic              partial;
    logic [WORD_W-1:0] word_aligned;
    logic [BW-1:0]     word_bits;
    logic              last_bit;
    logic              word_end;

    // A final partial word is left-aligned so that its bit r-1 leaves first
    // and the shift path can always take the register MSB.
    assign rem_ext      = 32'(rem);
    assign partial      = rem_ext < 32'(WORD_W);
    assign word_aligned = partial ? (in_data << (32'(WORD_W) - rem_ext)) : in_data;
    assign word_bits    = partial ? BW'(rem) : BW'(WORD_W);
    assign last_bit     = (rem == RW'(1));
    assign word_end     = (bit_cnt == BW'(1));

    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cfg_en     = 1'b0;
        cfg_head   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                cfg_en   = 1'b1;
                cfg_head = shreg[WORD_W-1];
                // Load completion takes priority over word exhaustion.
                if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end else if (word_end) begin
                    state_next = S_FETCH;
                end
            end
`ifdef CFG_LOADER_CRC_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            rem     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) rem <= RW'(CHAIN_LEN);
                S_FETCH: if (in_valid) bit_cnt <= word_bits;
                S_SHIFT: begin
                    rem     <= rem - RW'(1);
                    bit_cnt <= bit_cnt - BW'(1);
                end
                default: ;
            endcase
        end
    end

    // Data path only; its content is invisible outside SHIFT.
    always_ff @(posedge cfg_clk) begin
        if (state == S_FETCH && in_valid) begin
            shreg <= word_aligned;
        end else if (state == S_SHIFT) begin
            shreg <= shreg << 1;
        end
    end

`ifdef CFG_LOADER_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
        return {crc_in[14:0], 1'b0} ^ ((crc_in[15] ^ bit_in) ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] crc;
    logic        crc_err_q;

    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            crc       <= 16'hFFFF;
            crc_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        crc       <= 16'hFFFF;
                        crc_err_q <= 1'b0;
                    end
                end
                S_SHIFT: crc <= crc16_step(crc, cfg_head);
                S_CHECK: if (in_valid) crc_err_q <= (in_data[15:0] != crc);
                default: ;
            endcase
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_bitstream_loader
//
// Drives three loader instances (16/32, 40/16 and 16/16 chain/word geometry)
// with directed and randomised loads. Expected chain contents and CRC come
// from a bit-stream model built directly from the word list; a chain model
// collects what the DUT actually shifts out.
// -----------------------------------------------------------------------------
module tb_cfg_bitstream_loader;
    typedef bit          bitq_t[$];
    typedef logic [31:0] wordq_t[$];

    localparam int NI = 3;
`ifdef CFG_LOADER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic [NI-1:0]   rst_v;
    logic [NI-1:0]   start_v;
    logic [NI-1:0]   valid_v;
    logic [31:0]     data_v [NI];
    logic [NI-1:0]   ready_v, head_v, en_v, busy_v, done_v, err_v;

    int              checks = 0;
    int              failures = 0;
    int              en_cnt   [NI];
    int              done_cnt [NI];
    int              busy_cnt [NI];
    int              proto_bad[NI];
    logic [63:0]     chain    [NI];

    always #5 clk = ~clk;

    cfg_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(32)) u_a (
        .cfg_clk(clk), .cfg_rst(rst_v[0]), .start(start_v[0]),
        .in_data(data_v[0]), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
        .cfg_head(head_v[0]), .cfg_en(en_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .crc_err(err_v[0])
    );

    cfg_bitstream_loader #(.CHAIN_LEN(40), .WORD_W(16)) u_b (
        .cfg_clk(clk), .cfg_rst(rst_v[1]), .start(start_v[1]),
        .in_data(data_v[1][15:0]), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
        .cfg_head(head_v[1]), .cfg_en(en_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .crc_err(err_v[1])
    );

    cfg_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(16)) u_c (
        .cfg_clk(clk), .cfg_rst(rst_v[2]), .start(start_v[2]),
        .in_data(data_v[2][15:0]), .in_valid(valid_v[2]), .in_ready(ready_v[2]),
        .cfg_head(head_v[2]), .cfg_en(en_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .crc_err(err_v[2])
    );

    // Chain model plus per-cycle protocol counters, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (en_v[i] === 1'b1) begin
                en_cnt[i] <= en_cnt[i] + 1;
                chain[i]  <= {chain[i][62:0], head_v[i]};
            end
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
            if (busy_v[i] === 1'b1) busy_cnt[i] <= busy_cnt[i] + 1;
            if ((en_v[i] !== 1'b1 && head_v[i] !== 1'b0) ||
                (en_v[i] === 1'b1 && ready_v[i] !== 1'b0))
                proto_bad[i] <= proto_bad[i] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int cl_of(input int i);
        case (i)
            0:       return 16;
            1:       return 40;
            default: return 16;
        endcase
    endfunction

    function automatic int ww_of(input int i);
        case (i)
            0:       return 32;
            default: return 16;
        endcase
    endfunction

    // Bits in the order they must reach the chain: full words MSB first,
    // the final word contributing only as many low bits as remain.
    function automatic bitq_t ref_stream(input int cl, input int ww, input wordq_t w);
        bitq_t s;
        int    remaining;
        int    n;
        remaining = cl;
        foreach (w[k]) begin
            n = (remaining < ww) ? remaining : ww;
            for (int b = n - 1; b >= 0; b--) s.push_back(w[k][b]);
            remaining -= n;
        end
        return s;
    endfunction

    function automatic logic [15:0] ref_crc(input bitq_t s);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (s[i]) begin
            fb = c[15] ^ s[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present_word(input int inst, input logic [31:0] w, input string tag);
        int budget;
        data_v[inst]  = w;
        valid_v[inst] = 1'b1;
        budget = 0;
        while (ready_v[inst] !== 1'b1 && budget < 300) begin
            tick();
            budget++;
        end
        chk({tag, ".accept"}, 64'(budget < 300), 64'd1);
        tick();
        valid_v[inst] = 1'b0;
        data_v[inst]  = $urandom;
    endtask

    task automatic run_load(input int inst, input wordq_t words, input int stall_word,
                            input int stall_len, input bit poke_shift, input bit poke_done,
                            input bit bad_trailer, input string tag);
        int          cl, ww, en0, d0, b0, p0, budget, stall_cyc;
        bitq_t       s;
        logic [63:0] expc, mask;
        logic [15:0] crc_m;
        cl = cl_of(inst);
        ww = ww_of(inst);
        s  = ref_stream(cl, ww, words);
        expc = '0;
        foreach (s[i]) expc = {expc[62:0], s[i]};
        mask  = (64'd1 << cl) - 64'd1;
        crc_m = ref_crc(s);
        en0 = en_cnt[inst];
        d0  = done_cnt[inst];
        b0  = busy_cnt[inst];
        p0  = proto_bad[inst];
        stall_cyc = (stall_word >= 0 && stall_word < words.size()) ? stall_len : 0;

        start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        chk({tag, ".busy_on"}, 64'(busy_v[inst]), 64'd1);
        chk({tag, ".err_clr"}, 64'(err_v[inst]), 64'd0);

        foreach (words[k]) begin
            if (k == stall_word) begin
                valid_v[inst] = 1'b0;
                budget = 0;
                while (ready_v[inst] !== 1'b1 && budget < 200) begin
                    tick();
                    budget++;
                end
                repeat (stall_len) tick();
                chk({tag, ".stall_en"}, 64'(en_v[inst]), 64'd0);
                chk({tag, ".stall_ready"}, 64'(ready_v[inst]), 64'd1);
            end
            present_word(inst, words[k], tag);
            if (poke_shift && k == 0) begin
                chk({tag, ".poke_in_shift"}, 64'(en_v[inst]), 64'd1);
                start_v[inst] = 1'b1;
                tick();
                start_v[inst] = 1'b0;
            end
        end
        if (CRC_ON) present_word(inst, {16'h0000, crc_m ^ {15'd0, bad_trailer}}, {tag, ".trailer"});

        budget = 0;
        while (done_v[inst] !== 1'b1 && budget < 300) begin
            tick();
            budget++;
        end
        chk({tag, ".done_seen"}, 64'(budget < 300), 64'd1);
        if (poke_done) start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        chk({tag, ".busy_off"}, 64'(busy_v[inst]), 64'd0);
        chk({tag, ".done_off"}, 64'(done_v[inst]), 64'd0);
        repeat (3) tick();
        chk({tag, ".idle_after"}, 64'(busy_v[inst]), 64'd0);
        chk({tag, ".shifts"}, 64'(en_cnt[inst] - en0), 64'(cl));
        chk({tag, ".done_pulses"}, 64'(done_cnt[inst] - d0), 64'd1);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt[inst] - b0),
            64'(cl + words.size() + stall_cyc + (CRC_ON ? 1 : 0)));
        chk({tag, ".chain"}, chain[inst] & mask, expc);
        chk({tag, ".protocol"}, 64'(proto_bad[inst] - p0), 64'd0);
        chk({tag, ".crc_err"}, 64'(err_v[inst]), 64'(bad_trailer && CRC_ON));
    endtask

    initial begin
        wordq_t q;
        int     inst, n, sw, sl, en0, d0, budget;
        bit     bad;

        rst_v   = '1;
        start_v = '0;
        valid_v = '0;
        foreach (data_v[i]) data_v[i] = '0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst%0d.outs", i),
                64'({ready_v[i], head_v[i], en_v[i], busy_v[i], done_v[i], err_v[i]}), 64'd0);
        end
        rst_v = '0;
        tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("idle%0d.outs", i),
                64'({ready_v[i], head_v[i], en_v[i], busy_v[i], done_v[i], err_v[i]}), 64'd0);
        end

        // Single partial word: only the low 16 bits of 0xDEADBEEF reach the chain.
        q.delete();
        q.push_back(32'hDEADBEEF);
        run_load(0, q, -1, 0, 1'b0, 1'b0, 1'b0, "t1");
        chk("t1.beef", chain[0][15:0], 64'h0000_0000_0000_BEEF);

        // Three words, last one partial, then the same with a 10-cycle stall.
        q.delete();
        q.push_back(32'h1234);
        q.push_back(32'h5678);
        q.push_back(32'hFF9A);
        run_load(1, q, -1, 0, 1'b0, 1'b0, 1'b0, "t2");
        chk("t2.value", chain[1][39:0], 64'h12_3456_789A);
        run_load(1, q, 1, 10, 1'b0, 1'b0, 1'b0, "t3");
        chk("t3.value", chain[1][39:0], 64'h12_3456_789A);

        // Reset after 5 shifts of a 16-bit load, then a full load.
        en0 = en_cnt[2];
        d0  = done_cnt[2];
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        present_word(2, $urandom, "t4");
        budget = 0;
        while (en_cnt[2] - en0 < 4 && budget < 50) begin
            tick();
            budget++;
        end
        chk("t4.fifth_shift", 64'(en_v[2]), 64'd1);
        rst_v[2] = 1'b1;
        tick();
        chk("t4.en_low", 64'(en_v[2]), 64'd0);
        chk("t4.busy_low", 64'(busy_v[2]), 64'd0);
        rst_v[2] = 1'b0;
        repeat (4) tick();
        chk("t4.shift_count", 64'(en_cnt[2] - en0), 64'd5);
        chk("t4.no_done", 64'(done_cnt[2] - d0), 64'd0);
        q.delete();
        q.push_back(32'h0000_A5C3);
        run_load(2, q, -1, 0, 1'b0, 1'b0, 1'b0, "t4b");

        // start during SHIFT and during the DONE cycle is ignored.
        q.delete();
        q.push_back(32'h0BAD_F00D);
        run_load(0, q, -1, 0, 1'b1, 1'b1, 1'b0, "t5");

        // Trailer handling: good, bad (flag held while idle), then cleared by start.
        if (CRC_ON) begin
            q.delete();
            q.push_back(32'h0000_0000);
            run_load(2, q, -1, 0, 1'b0, 1'b0, 1'b0, "t6good");
            run_load(2, q, -1, 0, 1'b0, 1'b0, 1'b1, "t6bad");
            repeat (2) tick();
            chk("t6bad.held", 64'(err_v[2]), 64'd1);
            run_load(2, q, -1, 0, 1'b0, 1'b0, 1'b0, "t6clear");
        end

        for (int r = 0; r < 12; r++) begin
            inst = $urandom_range(0, NI - 1);
            n = (cl_of(inst) + ww_of(inst) - 1) / ww_of(inst);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back($urandom);
            if ($urandom_range(0, 1) == 1) begin
                sw = $urandom_range(0, n - 1);
                sl = $urandom_range(1, 6);
            end else begin
                sw = -1;
                sl = 0;
            end
            bad = 1'($urandom_range(0, 1));
            run_load(inst, q, sw, sl, 1'b0, 1'($urandom_range(0, 1)), bad,
                     $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream feeder for the configuration scan chain.
- Accepts configuration words over a valid/ready stream and serialises them onto the chain's head bit with a per-bit shift enable.
- Shifts exactly CHAIN_LEN bits per load, then reports completion.
- Sits between the bitstream source (host or ROM reader) and the chain's cfg_head/cfg_en inputs, on the same configuration clock.

Parameters:
- CHAIN_LEN, 16: total flops in the downstream chain; must be >= 1.
- WORD_W, 32: input word width; must be >= 1 (>= 16 when CFG_LOADER_CRC_EN is defined).

Ports:
- cfg_clk  input  1  configuration clock; the only clock.
- cfg_rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a load; sampled only in IDLE.
- in_data  input  WORD_W  configuration word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- cfg_head  output  1  serial bit to the chain head.
- cfg_en  output  1  chain shift enable; one chain shift per high cycle.
- busy  output  1  high from start acceptance until done.
- done  output  1  single-cycle pulse after the last shift (or after the CRC check).
- crc_err  output  1  CRC mismatch flag; see Optional Feature.

Behaviour:
- Reset values: in_ready=0, cfg_head=0, cfg_en=0, busy=0, done=0, crc_err=0, FSM=IDLE, counters=0.
- Reset at any time, including mid-load, returns to IDLE on the next edge.
  - cfg_en is low from the cycle after reset is sampled.
  - A partially shifted word is discarded.
  - Chain contents are not cleared.
- States: IDLE, FETCH, SHIFT, [CHECK], DONE.
- IDLE -> FETCH when start=1. busy goes high the next cycle.
- start while not in IDLE is ignored.
- FETCH:
  - in_ready=1, cfg_en=0.
  - On in_valid&&in_ready, latch the word into the shift register and go to SHIFT.
  - No timeout; the loader waits indefinitely for a word.
- SHIFT:
  - Each cycle: cfg_en=1, cfg_head = current bit. Bits go MSB first (bit WORD_W-1 down to bit 0).
  - The remaining-bit counter (width $clog2(CHAIN_LEN+1)) decrements per shift.
  - Word exhausted and bits remain -> FETCH. This leaves one bubble cycle with cfg_en=0 between words; it is legal for the chain.
  - Remaining count reaches 0 -> DONE, or CHECK if CRC is enabled.
- Final partial word, when CHAIN_LEN mod WORD_W = r != 0:
  - The last word shifts only its bits [r-1:0], starting at bit r-1.
  - Its upper bits are ignored.
- Words required per load = ceil(CHAIN_LEN/WORD_W).
- Resulting mapping: after completion, the first streamed bit sits at chain out[CHAIN_LEN-1] and the last at out[0].
- in_ready is low in all states except FETCH (and CHECK). Words presented outside those states are not consumed.
- cfg_en is high only in SHIFT. cfg_head holds 0 when cfg_en=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - start asserted in the DONE cycle is ignored.
  - start asserted the following cycle (IDLE) is accepted.
- Exactly CHAIN_LEN cfg_en-high cycles occur per completed load.

Optional Feature:
- Macro: CFG_LOADER_CRC_EN.
- When defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is updated with each cfg_head bit on every cfg_en cycle.
  - After the last shift, the FSM enters CHECK: in_ready=1, waiting for one trailer word. in_data[15:0] is compared against the CRC.
  - crc_err is set on mismatch and holds until the next accepted start or reset. DONE follows either way.
  - The CRC register is re-initialised on start.
- When undefined: no CHECK state, no trailer word is consumed, and crc_err is tied 0.

Test Plan:
- CHAIN_LEN=16, WORD_W=32, word 0xDEADBEEF -> 16 cfg_en cycles carrying bits 15..0 of 0xBEEF (1,0,1,1,1,1,1,0,1,1,1,0,1,1,1,1); chain model out=0xBEEF; one done pulse; busy low after.
- CHAIN_LEN=40, WORD_W=16, words 0x1234, 0x5678, 0xFF9A -> 40 shifts with 2 bubble cycles; third word contributes 0x9A only; chain out=0x1234_5678_9A.
- in_valid withheld for 10 cycles in the middle of the FETCH between words -> cfg_en stays 0, no extra shifts, final chain contents unchanged versus the no-stall case.
- cfg_rst asserted after 5 shifts of a 16-bit load -> cfg_en low the next cycle, busy=0, no done; a fresh start and full load then completes normally.
- start pulsed during SHIFT and on the DONE cycle -> ignored; exactly one load and one done pulse.
- CRC enabled, CHAIN_LEN=16, WORD_W=16, data 0x0000 -> bench reference model computes the expected CRC. Trailer equal to the model value -> crc_err=0. Trailer = model value XOR 0x0001 -> crc_err=1 after done; crc_err clears on the next start.
